// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with divide-by-zero and signed-overflow cases resolved at accept time.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_en
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        fn_q, fn_d;
  logic              neg_q, neg_d;
  logic [4:0]        rd_lat_q, rd_lat_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Accept-time operand conditioning
  logic            a_sgn, b_sgn, is_rem_in, neg_in, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_abs, b_abs, special_res;

  always_comb begin
    a_sgn       = op_a[XLEN-1] & (funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
    b_sgn       = op_b[XLEN-1] & (funct3 inside {3'b001, 3'b100, 3'b110});
    a_abs       = a_sgn ? -op_a : op_a;
    b_abs       = b_sgn ? -op_b : op_b;
    is_rem_in   = funct3[2] & funct3[1];
    // Remainder follows the dividend's sign; quotient/product follow the sign xor.
    neg_in      = is_rem_in ? a_sgn : (a_sgn ^ b_sgn);
    div_zero    = funct3[2] && (op_b == '0);
    div_ovf     = funct3[2] && !funct3[0] && (op_a == SMIN) && (op_b == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)     special_res = funct3[1] ? op_a : '1;
    else if (div_ovf) special_res = funct3[1] ? '0 : SMIN;
  end

  // One iteration; acc holds {hi,lo}: product/multiplier for MUL, remainder/quotient for DIV
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, step, prod_s;
  logic [XLEN-1:0]   mul_res, div_res, quo, rem;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step      = fn_q[2] ? div_next : mul_next;
    prod_s    = neg_q ? -step : step;
    mul_res   = (fn_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quo       = step[XLEN-1:0];
    rem       = step[2*XLEN-1:XLEN];
    div_res   = fn_q[1] ? (neg_q ? -rem : rem) : (neg_q ? -quo : quo);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    fn_d     = fn_q;
    neg_d    = neg_q;
    rd_lat_d = rd_lat_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        fn_d     = funct3;
        b_d      = b_abs;
        neg_d    = neg_in;
        rd_lat_d = rd_in;
        cnt_d    = '0;
        acc_d    = {{XLEN{1'b0}}, a_abs};
        if (special) begin
          state_d  = S_DONE;
          result_d = special_res;
          rd_out_d = rd_in;
        end else begin
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          state_d  = S_DONE;
          result_d = fn_q[2] ? div_res : mul_res;
          rd_out_d = rd_lat_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      fn_q     <= '0;
      neg_q    <= 1'b0;
      rd_lat_q <= '0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      fn_q     <= fn_d;
      neg_q    <= neg_d;
      rd_lat_q <= rd_lat_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;
  assign wb_en  = done && (rd_out_q != '0);

endmodule
